axi4_arbiter_2x1: RTL and testbench

Two-master to one-slave AXI4 arbiter feeding the AXI delay stage on its `in_*` side. Masters are the IFU on port 0 and the LSU on port 1. The arbiter serialises them into one transaction at a time (read or write), forwards bursts unchanged and routes responses back to the owning master. Only one transaction is outstanding on `out_*` at any time, so IDs pass through without remapping.

---
 rtl/axi4_arbiter_2x1_if.sv | 52 +++++
 rtl/axi4_arbiter_2x1.sv | 154 +++++++++++++++
 tb/tb_axi4_arbiter_2x1.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_arbiter_2x1_if.sv
// AXI4 bundle (AR/R/AW/W/B) shared by the arbiter's master-facing ports and
// its downstream port.
//   master modport : drives AR/AW/W valid+payload, rready, bready
//   slave  modport : drives arready/awready/wready, R and B valid+payload
interface axi4_arbiter_2x1_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready, rlast;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready, wlast;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rdata, rresp, rlast, output rready,
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready,
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready
  );
endinterface

// File: rtl/axi4_arbiter_2x1.sv
// Two-master (m0 = IFU, m1 = LSU) to one-slave AXI4 arbiter. Serialises the
// masters into a single outstanding transaction on `out`, forwards bursts
// unchanged and routes R/B back to the owning master. IDs pass through.
//   clock, resetn : rising-edge clock, async active-low reset
//   m0, m1        : master-facing AXI ports (slave modport)
//   out           : downstream AXI port (master modport)
// FIXED_PRIO=0 round-robins ties, FIXED_PRIO=1 always favours m0.
module axi4_arbiter_2x1 #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clock,
  input  logic                resetn,
  axi4_arbiter_2x1_if.slave   m0,
  axi4_arbiter_2x1_if.slave   m1,
  axi4_arbiter_2x1_if.master  out
);
  typedef enum logic [1:0] {IDLE, RD, WR, WB} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d, prio_q, prio_d;
  logic   aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic st_rd, st_wr, st_wb;
  assign st_rd = (state_q == RD);
  assign st_wr = (state_q == WR);
  assign st_wb = (state_q == WB);

  // Owner-selected request side.
  logic                own_arvalid, own_rready, own_awvalid, own_wvalid, own_wlast, own_bready;
  logic [ID_W-1:0]     own_arid, own_awid;
  logic [ADDR_W-1:0]   own_araddr, own_awaddr;
  logic [7:0]          own_arlen, own_awlen;
  logic [2:0]          own_arsize, own_awsize;
  logic [1:0]          own_arburst, own_awburst;
  logic [DATA_W-1:0]   own_wdata;
  logic [DATA_W/8-1:0] own_wstrb;

  always_comb begin
    if (owner_q) begin
      own_arvalid = m1.arvalid; own_arid = m1.arid; own_araddr = m1.araddr;
      own_arlen = m1.arlen; own_arsize = m1.arsize; own_arburst = m1.arburst;
      own_rready = m1.rready;
      own_awvalid = m1.awvalid; own_awid = m1.awid; own_awaddr = m1.awaddr;
      own_awlen = m1.awlen; own_awsize = m1.awsize; own_awburst = m1.awburst;
      own_wvalid = m1.wvalid; own_wdata = m1.wdata; own_wstrb = m1.wstrb; own_wlast = m1.wlast;
      own_bready = m1.bready;
    end else begin
      own_arvalid = m0.arvalid; own_arid = m0.arid; own_araddr = m0.araddr;
      own_arlen = m0.arlen; own_arsize = m0.arsize; own_arburst = m0.arburst;
      own_rready = m0.rready;
      own_awvalid = m0.awvalid; own_awid = m0.awid; own_awaddr = m0.awaddr;
      own_awlen = m0.awlen; own_awsize = m0.awsize; own_awburst = m0.awburst;
      own_wvalid = m0.wvalid; own_wdata = m0.wdata; own_wstrb = m0.wstrb; own_wlast = m0.wlast;
      own_bready = m0.bready;
    end
  end

  // Downstream: valids/readies gated purely by state, owner and done flags.
  assign out.arvalid = st_rd & own_arvalid;
  assign out.arid    = own_arid;
  assign out.araddr  = own_araddr;
  assign out.arlen   = own_arlen;
  assign out.arsize  = own_arsize;
  assign out.arburst = own_arburst;
  assign out.rready  = st_rd & own_rready;
  assign out.awvalid = st_wr & own_awvalid & ~aw_done_q;
  assign out.awid    = own_awid;
  assign out.awaddr  = own_awaddr;
  assign out.awlen   = own_awlen;
  assign out.awsize  = own_awsize;
  assign out.awburst = own_awburst;
  assign out.wvalid  = st_wr & own_wvalid & ~w_done_q;
  assign out.wdata   = own_wdata;
  assign out.wstrb   = own_wstrb;
  assign out.wlast   = own_wlast;
  assign out.bready  = st_wb & own_bready;

  // Master side: the non-owner never sees a ready or a response valid.
  assign m0.arready = st_rd & ~owner_q & out.arready;
  assign m1.arready = st_rd &  owner_q & out.arready;
  assign m0.awready = st_wr & ~owner_q & ~aw_done_q & out.awready;
  assign m1.awready = st_wr &  owner_q & ~aw_done_q & out.awready;
  assign m0.wready  = st_wr & ~owner_q & ~w_done_q & out.wready;
  assign m1.wready  = st_wr &  owner_q & ~w_done_q & out.wready;
  assign m0.rvalid  = st_rd & ~owner_q & out.rvalid;
  assign m1.rvalid  = st_rd &  owner_q & out.rvalid;
  assign m0.bvalid  = st_wb & ~owner_q & out.bvalid;
  assign m1.bvalid  = st_wb &  owner_q & out.bvalid;
  assign m0.rid = out.rid;  assign m0.rdata = out.rdata;
  assign m0.rresp = out.rresp; assign m0.rlast = out.rlast;
  assign m1.rid = out.rid;  assign m1.rdata = out.rdata;
  assign m1.rresp = out.rresp; assign m1.rlast = out.rlast;
  assign m0.bid = out.bid;  assign m0.bresp = out.bresp;
  assign m1.bid = out.bid;  assign m1.bresp = out.bresp;

  // Arbitration in IDLE. Only registered state reaches `out`, so a new
  // request costs one cycle and there is no valid-to-valid comb path.
  logic req0, req1, win, win_rd;
  assign req0   = m0.arvalid | m0.awvalid;
  assign req1   = m1.arvalid | m1.awvalid;
  assign win    = (req0 & req1) ? ((FIXED_PRIO != 0) ? 1'b0 : prio_q) : req1;
  assign win_rd = win ? m1.arvalid : m0.arvalid;

  logic go_idle;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    go_idle   = 1'b0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        owner_d   = win;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = win_rd ? RD : WR;
      end
      RD: go_idle = out.rvalid & out.rready & out.rlast;
      WR: begin
        // AW and W progress independently; leave once both have completed.
        aw_done_d = aw_done_q | (out.awvalid & out.awready);
        w_done_d  = w_done_q  | (out.wvalid & out.wready & out.wlast);
        if (aw_done_d && w_done_d) state_d = WB;
      end
      WB: go_idle = out.bvalid & out.bready;
      default: state_d = IDLE;
    endcase
    if (go_idle) begin
      state_d = IDLE;
      if (FIXED_PRIO == 0) prio_d = ~owner_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi4_arbiter_2x1.sv
// Directed bench for axi4_arbiter_2x1: round-robin instance plus a
// FIXED_PRIO=1 instance. Inputs change just after the falling edge and
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_axi4_arbiter_2x1;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  axi4_arbiter_2x1_if m0(), m1(), so();
  axi4_arbiter_2x1_if f0(), f1(), fs();

  axi4_arbiter_2x1 #(.FIXED_PRIO(0)) dut (
    .clock(clock), .resetn(resetn), .m0(m0), .m1(m1), .out(so));
  axi4_arbiter_2x1 #(.FIXED_PRIO(1)) dut_fp (
    .clock(clock), .resetn(resetn), .m0(f0), .m1(f1), .out(fs));

  task automatic cyc(); @(negedge clock); endtask

  function automatic logic [14:0] vr();
    return {so.arvalid, so.awvalid, so.wvalid, so.rready, so.bready,
            m0.arready, m0.awready, m0.wready, m0.rvalid, m0.bvalid,
            m1.arready, m1.awready, m1.wready, m1.rvalid, m1.bvalid};
  endfunction

  task automatic init();
    m0.arvalid = 0; m0.arid = 0; m0.araddr = 0; m0.arlen = 0; m0.arsize = 3'd2; m0.arburst = 2'd1;
    m0.rready = 0; m0.awvalid = 0; m0.awid = 0; m0.awaddr = 0; m0.awlen = 0; m0.awsize = 3'd2;
    m0.awburst = 2'd1; m0.wvalid = 0; m0.wdata = 0; m0.wstrb = 4'hf; m0.wlast = 0; m0.bready = 0;
    m1.arvalid = 0; m1.arid = 0; m1.araddr = 0; m1.arlen = 0; m1.arsize = 3'd2; m1.arburst = 2'd1;
    m1.rready = 0; m1.awvalid = 0; m1.awid = 0; m1.awaddr = 0; m1.awlen = 0; m1.awsize = 3'd2;
    m1.awburst = 2'd1; m1.wvalid = 0; m1.wdata = 0; m1.wstrb = 4'hf; m1.wlast = 0; m1.bready = 0;
    f0.arvalid = 0; f0.arid = 0; f0.araddr = 0; f0.arlen = 0; f0.arsize = 3'd2; f0.arburst = 2'd1;
    f0.rready = 0; f0.awvalid = 0; f0.awid = 0; f0.awaddr = 0; f0.awlen = 0; f0.awsize = 3'd2;
    f0.awburst = 2'd1; f0.wvalid = 0; f0.wdata = 0; f0.wstrb = 4'hf; f0.wlast = 0; f0.bready = 0;
    f1.arvalid = 0; f1.arid = 0; f1.araddr = 0; f1.arlen = 0; f1.arsize = 3'd2; f1.arburst = 2'd1;
    f1.rready = 0; f1.awvalid = 0; f1.awid = 0; f1.awaddr = 0; f1.awlen = 0; f1.awsize = 3'd2;
    f1.awburst = 2'd1; f1.wvalid = 0; f1.wdata = 0; f1.wstrb = 4'hf; f1.wlast = 0; f1.bready = 0;
    so.arready = 0; so.rvalid = 0; so.rid = 0; so.rdata = 0; so.rresp = 0; so.rlast = 0;
    so.awready = 0; so.wready = 0; so.bvalid = 0; so.bid = 0; so.bresp = 0;
    fs.arready = 0; fs.rvalid = 0; fs.rid = 0; fs.rdata = 0; fs.rresp = 0; fs.rlast = 0;
    fs.awready = 0; fs.wready = 0; fs.bvalid = 0; fs.bid = 0; fs.bresp = 0;
  endtask

  // Slave-side AR acceptance: waits (bounded) for out_arvalid, accepts one
  // address and reports which master saw arready (-1 if none).
  task automatic accept_ar(output int who, output logic [31:0] addr);
    who = -1; addr = '0;
    for (int i = 0; i < 8 && so.arvalid !== 1'b1; i++) cyc();
    if (so.arvalid === 1'b1) begin
      so.arready = 1; #1;
      who  = (m1.arready === 1'b1) ? 1 : (m0.arready === 1'b1) ? 0 : -1;
      addr = so.araddr;
      cyc();
      so.arready = 0;
    end
  endtask

  task automatic test_reset();
    #2;
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL reset_quiet: got %b exp 0", vr()); end
    cyc(); cyc(); resetn = 1;
    // Stray responses in IDLE must be neither accepted nor forwarded.
    so.rvalid = 1; so.bvalid = 1; #1;
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL idle_resp_blocked: got %b exp 0", vr()); end
    so.rvalid = 0; so.bvalid = 0;
    cyc();
  endtask

  task automatic test_single_reads();
    m0.arvalid = 1; m0.araddr = 32'h3000_0000; m0.arlen = 0; m0.arid = 4'h2; m0.rready = 1; #1;
    tests++; if (so.arvalid !== 1'b0) begin fails++; $display("FAIL m0_no_comb_grant: got %b exp 0", so.arvalid); end
    cyc();
    tests++; if ({so.arvalid, so.araddr, so.arlen, so.arid} !== {1'b1, 32'h3000_0000, 8'd0, 4'h2}) begin
      fails++; $display("FAIL m0_grant: got %b %h %0d exp 1 30000000 0", so.arvalid, so.araddr, so.arlen); end
    so.arready = 1; #1;
    tests++; if ({m0.arready, m1.arready} !== 2'b10) begin fails++; $display("FAIL m0_arready: got %b exp 10", {m0.arready, m1.arready}); end
    cyc(); so.arready = 0; m0.arvalid = 0;
    so.rvalid = 1; so.rdata = 32'hA5A5_0000; so.rlast = 1; so.rid = 4'h2; #1;
    tests++; if ({m0.rvalid, m1.rvalid, so.rready, m0.rlast, m0.rdata} !== {4'b1011, 32'hA5A5_0000}) begin
      fails++; $display("FAIL m0_rbeat: got %b%b%b %h exp 101 a5a50000", m0.rvalid, m1.rvalid, so.rready, m0.rdata); end
    cyc(); so.rvalid = 0; #1;
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL m0_turnaround: got %b exp 0", vr()); end

    m1.arvalid = 1; m1.araddr = 32'h8000_0010; m1.arlen = 3; m1.arid = 4'h5; m1.rready = 1; #1;
    tests++; if (so.arvalid !== 1'b0) begin fails++; $display("FAIL m1_no_comb_grant: got %b exp 0", so.arvalid); end
    cyc();
    tests++; if ({so.arvalid, so.araddr, so.arlen} !== {1'b1, 32'h8000_0010, 8'd3}) begin
      fails++; $display("FAIL m1_grant: got %b %h %0d exp 1 80000010 3", so.arvalid, so.araddr, so.arlen); end
    so.arready = 1; #1;
    tests++; if ({m1.arready, m0.arready} !== 2'b10) begin fails++; $display("FAIL m1_arready: got %b exp 10", {m1.arready, m0.arready}); end
    cyc(); so.arready = 0; m1.arvalid = 0;
    for (int b = 0; b < 4; b++) begin
      so.rvalid = 1; so.rdata = 32'h1000 + b; so.rlast = (b == 3); so.rid = 4'h5; #1;
      tests++;
      if ({m1.rvalid, m0.rvalid, m1.rlast, m1.rdata} !== {2'b10, (b == 3), 32'h1000 + b}) begin
        fails++; $display("FAIL m1_beat%0d: got v=%b%b last=%b d=%h", b, m1.rvalid, m0.rvalid, m1.rlast, m1.rdata); end
      cyc();
    end
    so.rvalid = 0; so.rlast = 0; #1;
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL m1_done: got %b exp 0", vr()); end
  endtask

  task automatic test_round_robin();
    int who; logic [31:0] addr; int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    m0.arvalid = 1; m0.araddr = 32'h100; m0.arlen = 0; m0.rready = 1;
    m1.arvalid = 1; m1.araddr = 32'h200; m1.arlen = 0; m1.rready = 1;
    for (int g = 0; g < 4; g++) begin
      accept_ar(who, addr);
      tests++;
      if (who !== exp_g[g] || addr !== (exp_g[g] == 1 ? 32'h200 : 32'h100)) begin
        fails++; $display("FAIL rr_grant%0d: got m%0d %h exp m%0d", g, who, addr, exp_g[g]); end
      so.rvalid = 1; so.rlast = 1; so.rdata = g; #1;
      cyc(); so.rvalid = 0; so.rlast = 0; #1;
      tests++; if (so.arvalid !== 1'b0) begin fails++; $display("FAIL rr_gap%0d: got %b exp 0", g, so.arvalid); end
    end
    m0.arvalid = 0; m1.arvalid = 0;
  endtask

  task automatic test_fixed_prio();
    f0.arvalid = 1; f0.araddr = 32'h10; f0.rready = 1;
    f1.arvalid = 1; f1.araddr = 32'h20; f1.rready = 1;
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 8 && fs.arvalid !== 1'b1; i++) cyc();
      fs.arready = 1; #1;
      tests++; if ({f0.arready, f1.arready} !== 2'b10) begin
        fails++; $display("FAIL fp_grant%0d: got %b exp 10", g, {f0.arready, f1.arready}); end
      cyc(); fs.arready = 0;
      fs.rvalid = 1; fs.rlast = 1; #1;
      cyc(); fs.rvalid = 0; fs.rlast = 0;
    end
    f0.arvalid = 0; f1.arvalid = 0; f0.rready = 0; f1.rready = 0;
    cyc();
  endtask

  task automatic test_read_over_write();
    m1.arvalid = 1; m1.araddr = 32'h40; m1.arlen = 0; m1.rready = 1;
    m1.awvalid = 1; m1.awaddr = 32'h50; m1.awlen = 0; m1.bready = 1;
    m1.wvalid = 1; m1.wdata = 32'hDEAD_BEEF; m1.wlast = 1;
    cyc();
    tests++; if ({so.arvalid, so.awvalid, so.wvalid} !== 3'b100) begin
      fails++; $display("FAIL rw_read_first: got %b exp 100", {so.arvalid, so.awvalid, so.wvalid}); end
    so.arready = 1; cyc(); so.arready = 0; m1.arvalid = 0;
    so.rvalid = 1; so.rlast = 1; #1;
    cyc(); so.rvalid = 0; so.rlast = 0; #1;
    tests++; if ({so.arvalid, so.awvalid, so.wvalid} !== 3'b000) begin
      fails++; $display("FAIL rw_idle_gap: got %b exp 000", {so.arvalid, so.awvalid, so.wvalid}); end
    cyc();
    tests++; if ({so.arvalid, so.awvalid, so.wvalid, so.awaddr} !== {3'b011, 32'h50}) begin
      fails++; $display("FAIL rw_write_next: got %b %h exp 011 50", {so.arvalid, so.awvalid, so.wvalid}, so.awaddr); end
    so.awready = 1; so.wready = 1; #1;
    tests++; if ({m1.awready, m1.wready, m0.awready, m0.wready} !== 4'b1100) begin
      fails++; $display("FAIL rw_wr_ready: got %b exp 1100", {m1.awready, m1.wready, m0.awready, m0.wready}); end
    cyc(); so.awready = 0; so.wready = 0; m1.awvalid = 0; m1.wvalid = 0; m1.wlast = 0;
    so.bvalid = 1; so.bresp = 2'b00; #1;
    tests++; if ({m1.bvalid, m0.bvalid, so.bready, so.awvalid, so.wvalid} !== 5'b10100) begin
      fails++; $display("FAIL rw_b_route: got %b exp 10100", {m1.bvalid, m0.bvalid, so.bready, so.awvalid, so.wvalid}); end
    cyc(); so.bvalid = 0; #1;
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL rw_done: got %b exp 0", vr()); end
  endtask

  task automatic test_w_before_aw();
    m1.awvalid = 1; m1.awaddr = 32'h9000; m1.awlen = 1; m1.awid = 4'h3; m1.bready = 1;
    m1.wvalid = 1; m1.wdata = 32'h1111_0000; m1.wlast = 0;
    so.wready = 1; so.awready = 0; so.bvalid = 1; so.bid = 4'h3; so.bresp = 2'b10; #1;
    tests++; if ({m1.bvalid, so.bready} !== 2'b00) begin fails++; $display("FAIL wb_idle_b: got %b exp 00", {m1.bvalid, so.bready}); end
    cyc();
    tests++; if ({so.awvalid, so.wvalid, m1.wready, m1.awready, m1.bvalid, so.bready, so.wdata} !== {6'b111000, 32'h1111_0000}) begin
      fails++; $display("FAIL wb_beat0: got %b %h exp 111000 11110000",
                        {so.awvalid, so.wvalid, m1.wready, m1.awready, m1.bvalid, so.bready}, so.wdata); end
    cyc(); m1.wdata = 32'h2222_0001; m1.wlast = 1; #1;
    tests++; if ({so.wvalid, so.wlast, so.wdata} !== {2'b11, 32'h2222_0001}) begin
      fails++; $display("FAIL wb_beat1: got %b%b %h exp 11 22220001", so.wvalid, so.wlast, so.wdata); end
    cyc();  // master keeps wvalid high: the arbiter must gate it after wlast
    tests++; if ({so.wvalid, m1.wready, so.awvalid, m1.bvalid, so.bready} !== 5'b00100) begin
      fails++; $display("FAIL wb_w_gated: got %b exp 00100", {so.wvalid, m1.wready, so.awvalid, m1.bvalid, so.bready}); end
    so.awready = 1; #1;
    tests++; if (m1.awready !== 1'b1) begin fails++; $display("FAIL wb_awready: got %b exp 1", m1.awready); end
    cyc(); so.awready = 0; m1.awvalid = 0; m1.wvalid = 0; m1.wlast = 0; #1;
    tests++; if ({m1.bvalid, so.bready, m0.bvalid, so.awvalid, m1.bresp, m1.bid} !== {4'b1100, 2'b10, 4'h3}) begin
      fails++; $display("FAIL wb_b_routed: got %b %b %h exp 1100 10 3",
                        {m1.bvalid, so.bready, m0.bvalid, so.awvalid}, m1.bresp, m1.bid); end
    cyc(); so.bvalid = 0; so.wready = 0; #1;
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL wb_done: got %b exp 0", vr()); end
  endtask

  task automatic test_backpressure();
    int who; logic [31:0] addr; int b; int got; int cnt;
    m0.arvalid = 1; m0.araddr = 32'h500; m0.arlen = 3; m0.rready = 1;
    accept_ar(who, addr);
    m0.arvalid = 0;
    tests++; if (who !== 0) begin fails++; $display("FAIL bp_grant: got m%0d exp m0", who); end
    b = 0; got = 0; cnt = 0;
    so.rvalid = 1;
    while (b < 4 && cnt < 30) begin
      so.rdata = 32'h700 + b; so.rlast = (b == 3);
      m0.rready = !(cnt >= 2 && cnt < 7); #1;
      if (m0.rready == 1'b0) begin
        tests++; if ({so.rready, m0.rvalid} !== 2'b01) begin
          fails++; $display("FAIL bp_stall%0d: got %b exp 01", cnt, {so.rready, m0.rvalid}); end
      end
      if (m0.rvalid === 1'b1 && m0.rready === 1'b1) begin
        tests++; if (m0.rdata !== 32'h700 + got) begin
          fails++; $display("FAIL bp_data%0d: got %h exp %h", got, m0.rdata, 32'h700 + got); end
        got++;
      end
      if (so.rready === 1'b1) b++;
      cnt++;
      cyc();
    end
    so.rvalid = 0; so.rlast = 0; #1;
    tests++; if (got !== 4 || b !== 4) begin fails++; $display("FAIL bp_count: got %0d/%0d exp 4/4", got, b); end
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL bp_done: got %b exp 0", vr()); end
  endtask

  task automatic test_reset_mid_burst();
    int who; logic [31:0] addr;
    m0.arvalid = 1; m0.araddr = 32'h600; m0.arlen = 3; m0.rready = 1;
    accept_ar(who, addr);
    m0.arvalid = 0;
    for (int i = 0; i < 2; i++) begin
      so.rvalid = 1; so.rdata = 32'h900 + i; so.rlast = 0; cyc();
    end
    so.rvalid = 1; so.rdata = 32'h902; #1;
    tests++; if (m0.rvalid !== 1'b1) begin fails++; $display("FAIL rst_pre: got %b exp 1", m0.rvalid); end
    #1 resetn = 0; #1;
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL rst_async_quiet: got %b exp 0", vr()); end
    m1.arvalid = 1; m1.araddr = 32'hA00; m1.arlen = 0; m1.rready = 1;
    cyc(); #1;
    tests++; if (vr() !== 15'd0) begin fails++; $display("FAIL rst_held: got %b exp 0", vr()); end
    so.rvalid = 0; resetn = 1; #1;
    tests++; if (so.arvalid !== 1'b0) begin fails++; $display("FAIL rst_idle: got %b exp 0", so.arvalid); end
    cyc();
    tests++; if ({so.arvalid, so.araddr} !== {1'b1, 32'hA00}) begin
      fails++; $display("FAIL rst_regrant: got %b %h exp 1 a00", so.arvalid, so.araddr); end
    so.arready = 1; #1;
    tests++; if ({m1.arready, m0.arready} !== 2'b10) begin fails++; $display("FAIL rst_m1_ar: got %b exp 10", {m1.arready, m0.arready}); end
    cyc(); so.arready = 0; m1.arvalid = 0;
    so.rvalid = 1; so.rlast = 1; so.rdata = 32'hB00; #1;
    tests++; if ({m1.rvalid, m0.rvalid, m1.rdata} !== {2'b10, 32'hB00}) begin
      fails++; $display("FAIL rst_m1_r: got %b %h exp 10 b00", {m1.rvalid, m0.rvalid}, m1.rdata); end
    cyc(); so.rvalid = 0; so.rlast = 0;
  endtask

  initial begin
    init();
    test_reset();
    test_single_reads();
    test_round_robin();
    test_fixed_prio();
    test_read_over_write();
    test_w_before_aw();
    test_backpressure();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
